// File: rtl/axi_mm2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mm2s_pkg
// Description : Shared encodings for the MM2S read-slave model: AXI burst
//               types, R responses, data-pattern modes, engine FSM states
//               and the burst legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mm2s_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam int c_PAT_CONST = 0;
    localparam int c_PAT_ADDR  = 1;
    localparam int c_PAT_COUNT = 2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BEAT  = 2'd2;
    localparam logic [1:0] c_ST_STALL = 2'd3;

    // A burst is answered with SLVERR when its type is WRAP/reserved or
    // its beat size is wider than the data bus.
    function automatic logic burst_is_err(input logic [1:0]  burst,
                                          input logic [2:0]  size,
                                          input int unsigned bus_bytes);
        logic bad_burst;
        case (burst)
            c_BURST_FIXED: bad_burst = 1'b0;
            c_BURST_INCR:  bad_burst = 1'b0;
            c_BURST_WRAP:  bad_burst = 1'b1;
            default:       bad_burst = 1'b1;
        endcase
        return bad_burst || ((32'd1 << size) > bus_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ar_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_ar_fifo
// Description : Synchronous FIFO holding accepted AR requests.
//               clk    - clock
//               rst_n  - synchronous active-low reset (empties the queue)
//               push   - write din (ignored when full)
//               pop    - drop head entry (ignored when empty)
//               din    - entry to store
//               dout   - head entry (valid while !empty)
//               full   - occupancy == DEPTH
//               empty  - occupancy == 0
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ar_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_mm2s_rd_model.sv
`default_nettype none
// ============================================================================
// Module      : axi_mm2s_rd_model
// Description : AXI4 memory-read slave model for DMA MM2S bring-up. Queues
//               AR requests, waits AR_LATENCY cycles, then returns ARLEN+1
//               beats of patterned data with RLAST framing, optional RVALID
//               bubbles, SLVERR for illegal bursts and status counters.
//               S_AXI_ACLK/ARESETN   - clock, synchronous active-low reset
//               S_AXI_AR*            - read address channel (slave side)
//               S_AXI_R*             - read data channel (slave side)
//               bursts_done          - bursts completed (wrapping)
//               err_bursts           - SLVERR bursts completed (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mm2s_rd_model
    import axi_mm2s_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          AR_FIFO_DEPTH = 4,
    parameter int          AR_LATENCY    = 2,
    parameter int          PATTERN_MODE  = 1,
    parameter logic [31:0] CONST_DATA    = 32'h5A5A_5A5A,
    parameter int          STALL_PERIOD  = 0
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [15:0]           bursts_done,
    output logic [15:0]           err_bursts
);

    localparam int          c_FIFO_W    = ADDR_WIDTH + 13;
    localparam int unsigned c_BUS_BYTES = DATA_WIDTH / 8;
    localparam int unsigned c_STALL_DIV = (STALL_PERIOD == 0) ? 1 : STALL_PERIOD;
    localparam logic [3:0]  c_LAT_M1    = 4'(AR_LATENCY - 1);

    logic [c_FIFO_W-1:0]   w_fifo_din;
    logic [c_FIFO_W-1:0]   w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [7:0]            w_head_len;
    logic [2:0]            w_head_size;
    logic [1:0]            w_head_burst;

    logic [1:0]            r_state;
    logic                  r_ar_en;
    logic [3:0]            r_wait;
    logic [7:0]            r_beat;
    logic [7:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_step;
    logic                  r_incr;
    logic                  r_err;
    logic [31:0]           r_pat_cnt;
    logic [15:0]           r_done;
    logic [15:0]           r_err_cnt;

    logic                  w_valid;
    logic                  w_last;
    logic [8:0]            w_acc_cnt;
    logic                  w_stall_hit;
    logic [31:0]           w_addr32;
    logic [31:0]           w_word;

    // ARREADY is held low until the first clock after reset release.
    assign S_AXI_ARREADY = r_ar_en && !w_fifo_full;
    assign w_push        = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_pop         = (r_state == c_ST_IDLE) && !w_fifo_empty;
    assign w_fifo_din    = {S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST};

    assign w_head_addr  = w_fifo_dout[c_FIFO_W-1 -: ADDR_WIDTH];
    assign w_head_len   = w_fifo_dout[12:5];
    assign w_head_size  = w_fifo_dout[4:2];
    assign w_head_burst = w_fifo_dout[1:0];

    axi_ar_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (AR_FIFO_DEPTH)
    ) u_ar_fifo (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_valid   = (r_state == c_ST_BEAT);
    assign w_last    = (r_beat == r_len);
    // Beats accepted so far in this burst, including the one handshaking now.
    assign w_acc_cnt = {1'b0, r_beat} + 9'd1;
    assign w_stall_hit = (STALL_PERIOD != 0) &&
                         ((32'(w_acc_cnt) % c_STALL_DIV) == 32'd0);

    generate
        if (ADDR_WIDTH >= 32) begin : g_addr_trunc
            assign w_addr32 = r_addr[31:0];
        end else begin : g_addr_ext
            assign w_addr32 = {{(32-ADDR_WIDTH){1'b0}}, r_addr};
        end
    endgenerate

    always_comb begin
        w_word = r_pat_cnt;
        case (PATTERN_MODE)
            c_PAT_CONST: w_word = CONST_DATA;
            c_PAT_ADDR:  w_word = w_addr32;
            default:     w_word = r_pat_cnt;
        endcase
    end

    // All R outputs are derived from registered engine state, so they stay
    // stable while RVALID is held against a low RREADY.
    assign S_AXI_RVALID = w_valid;
    assign S_AXI_RLAST  = w_valid && w_last;
    assign S_AXI_RRESP  = (w_valid && r_err) ? c_RESP_SLVERR : c_RESP_OKAY;
    assign S_AXI_RDATA  = (w_valid && !r_err) ? {(DATA_WIDTH/32){w_word}} : '0;
    assign bursts_done  = r_done;
    assign err_bursts   = r_err_cnt;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= c_ST_IDLE;
            r_ar_en   <= 1'b0;
            r_wait    <= '0;
            r_beat    <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_step    <= '0;
            r_incr    <= 1'b0;
            r_err     <= 1'b0;
            r_pat_cnt <= '0;
            r_done    <= '0;
            r_err_cnt <= '0;
        end else begin
            r_ar_en <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_addr <= w_head_addr;
                        r_len  <= w_head_len;
                        r_step <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << w_head_size;
                        r_incr <= (w_head_burst == c_BURST_INCR);
                        r_err  <= burst_is_err(w_head_burst, w_head_size, c_BUS_BYTES);
                        r_beat <= '0;
                        if (AR_LATENCY > 0) begin
                            r_state <= c_ST_WAIT;
                            r_wait  <= c_LAT_M1;
                        end else begin
                            r_state <= c_ST_BEAT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_state <= c_ST_BEAT;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                c_ST_BEAT: begin
                    if (S_AXI_RREADY) begin
                        r_pat_cnt <= r_pat_cnt + 32'd1;
                        if (w_last) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= r_done + 16'd1;
                            if (r_err && (r_err_cnt != 16'hFFFF)) begin
                                r_err_cnt <= r_err_cnt + 16'd1;
                            end
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            if (r_incr) begin
                                r_addr <= r_addr + r_step;
                            end
                            if (w_stall_hit) begin
                                r_state <= c_ST_STALL;
                            end
                        end
                    end
                end
                c_ST_STALL: begin
                    r_state <= c_ST_BEAT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mm2s_rd_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mm2s_rd_model
// Description : Self-checking bench for axi_mm2s_rd_model. Instance A uses
//               the address pattern without bubbles; instance B uses the
//               running counter with a bubble every 2 beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mm2s_rd_model;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_resp;
        logic [31:0] exp_first;
        logic [31:0] exp_step;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [31:0] a_araddr, b_araddr;
    logic [7:0]  a_arlen, b_arlen;
    logic [2:0]  a_arsize, b_arsize;
    logic [1:0]  a_arburst, b_arburst;
    logic        a_arvalid, b_arvalid, a_arready, b_arready;
    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_rresp, b_rresp;
    logic        a_rlast, b_rlast, a_rvalid, b_rvalid, a_rready, b_rready;
    logic [15:0] a_done, b_done, a_err, b_err;

    axi_mm2s_rd_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .AR_FIFO_DEPTH(4), .AR_LATENCY(2),
        .PATTERN_MODE(1), .CONST_DATA(32'h5A5A_5A5A), .STALL_PERIOD(0)
    ) u_dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_ARADDR(a_araddr), .S_AXI_ARLEN(a_arlen), .S_AXI_ARSIZE(a_arsize),
        .S_AXI_ARBURST(a_arburst), .S_AXI_ARVALID(a_arvalid), .S_AXI_ARREADY(a_arready),
        .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RLAST(a_rlast),
        .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(a_rready),
        .bursts_done(a_done), .err_bursts(a_err)
    );

    axi_mm2s_rd_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .AR_FIFO_DEPTH(4), .AR_LATENCY(2),
        .PATTERN_MODE(2), .CONST_DATA(32'h5A5A_5A5A), .STALL_PERIOD(2)
    ) u_dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_ARADDR(b_araddr), .S_AXI_ARLEN(b_arlen), .S_AXI_ARSIZE(b_arsize),
        .S_AXI_ARBURST(b_arburst), .S_AXI_ARVALID(b_arvalid), .S_AXI_ARREADY(b_arready),
        .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RLAST(b_rlast),
        .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(b_rready),
        .bursts_done(b_done), .err_bursts(b_err)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t qa[$];
    beat_t qb[$];
    vec_t  vecs[8];

    logic        a_hold = 1'b0, b_hold = 1'b0;
    logic [31:0] a_hold_data, b_hold_data;
    logic        a_hold_last, b_hold_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp_beat(input string tag, ref beat_t q[$], input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        beat_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_beat actual=%h required=none", tag, data);
        end else begin
            e = q.pop_front();
            chk({tag, "_rdata"}, data, e.data);
            chk({tag, "_rresp"}, 32'(resp), 32'(e.resp));
            chk({tag, "_rlast"}, 32'(last), 32'(e.last));
        end
    endtask

    // Score the beats handshaking at the coming edge, check hold stability,
    // then advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        if (a_rvalid && a_rready) cmp_beat("a", qa, a_rdata, a_rresp, a_rlast);
        if (b_rvalid && b_rready) cmp_beat("b", qb, b_rdata, b_rresp, b_rlast);
        if (a_hold) begin
            chk("a_hold_rvalid", 32'(a_rvalid), 32'd1);
            chk("a_hold_rdata", a_rdata, a_hold_data);
            chk("a_hold_rlast", 32'(a_rlast), 32'(a_hold_last));
        end
        if (b_hold) begin
            chk("b_hold_rvalid", 32'(b_rvalid), 32'd1);
            chk("b_hold_rdata", b_rdata, b_hold_data);
            chk("b_hold_rlast", 32'(b_rlast), 32'(b_hold_last));
        end
        a_hold = a_rvalid && !a_rready;
        a_hold_data = a_rdata;
        a_hold_last = a_rlast;
        b_hold = b_rvalid && !b_rready;
        b_hold_data = b_rdata;
        b_hold_last = b_rlast;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp_a(input vec_t v);
        beat_t e;
        for (int i = 0; i <= int'(v.len); i++) begin
            e.resp = v.exp_resp;
            e.data = (v.exp_resp == 2'b10) ? 32'd0 : v.exp_first + 32'(i) * v.exp_step;
            e.last = (i == int'(v.len));
            qa.push_back(e);
        end
    endtask

    task automatic push_cnt_b(input logic [31:0] start, input int len);
        beat_t e;
        for (int i = 0; i <= len; i++) begin
            e.resp = 2'b00;
            e.data = start + 32'(i);
            e.last = (i == len);
            qb.push_back(e);
        end
    endtask

    task automatic issue_a(input vec_t v);
        int n = 0;
        a_araddr = v.addr; a_arlen = v.len; a_arsize = v.size; a_arburst = v.burst;
        a_arvalid = 1'b1;
        while (!a_arready && n < 50) begin tick(); n++; end
        chk("a_issue_arready", 32'(a_arready), 32'd1);
        push_exp_a(v);
        tick();
        a_arvalid = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] len);
        int n = 0;
        b_araddr = 32'h0; b_arlen = len; b_arsize = 3'd2; b_arburst = 2'b01;
        b_arvalid = 1'b1;
        while (!b_arready && n < 50) begin tick(); n++; end
        chk("b_issue_arready", 32'(b_arready), 32'd1);
        tick();
        b_arvalid = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while (qa.size() != 0 && n < budget) begin tick(); n++; end
        chk("a_drain_left", 32'(qa.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          cnt;
        logic [6:0]  exp_ready;
        logic [7:0]  stall_pat;
        vec_t        v;

        vecs[0] = '{32'h1000,     8'd3, 3'd2, 2'b01, 2'b00, 32'h1000,     32'd4};
        vecs[1] = '{32'h2000,     8'd0, 3'd2, 2'b01, 2'b00, 32'h2000,     32'd4};
        vecs[2] = '{32'h3000,     8'd2, 3'd2, 2'b00, 2'b00, 32'h3000,     32'd0};
        vecs[3] = '{32'h4000,     8'd3, 3'd2, 2'b10, 2'b10, 32'h0,        32'd0};
        vecs[4] = '{32'h5000,     8'd3, 3'd3, 2'b01, 2'b10, 32'h0,        32'd0};
        vecs[5] = '{32'h6001,     8'd2, 3'd0, 2'b01, 2'b00, 32'h6001,     32'd1};
        vecs[6] = '{32'hFFFFFFFE, 8'd2, 3'd1, 2'b01, 2'b00, 32'hFFFFFFFE, 32'd2};
        vecs[7] = '{32'h7000,     8'd1, 3'd2, 2'b11, 2'b10, 32'h0,        32'd0};

        rstn = 1'b0;
        a_araddr = '0; a_arlen = '0; a_arsize = '0; a_arburst = '0; a_arvalid = 1'b0; a_rready = 1'b0;
        b_araddr = '0; b_arlen = '0; b_arsize = '0; b_arburst = '0; b_arvalid = 1'b0; b_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_arready", 32'(a_arready), 32'd0);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rlast", 32'(a_rlast), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_rresp", 32'(a_rresp), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        rstn = 1'b1;
        tick();
        chk("rel_arready_a", 32'(a_arready), 32'd1);
        chk("rel_arready_b", 32'(b_arready), 32'd1);

        // First-beat latency, counted in edges from the AR handshake edge
        a_rready = 1'b1;
        a_araddr = vecs[0].addr; a_arlen = vecs[0].len; a_arsize = vecs[0].size; a_arburst = vecs[0].burst;
        chk("lat_arready", 32'(a_arready), 32'd1);
        push_exp_a(vecs[0]);
        a_arvalid = 1'b1;
        tick();
        a_arvalid = 1'b0;
        n = 1;
        while (!a_rvalid && n < 20) begin tick(); n++; end
        chk("lat_first_rvalid", 32'(n), 32'd4);
        drain_a(50);
        chk("lat_done", 32'(a_done), 32'd1);

        // Table of bursts: INCR, single, FIXED, WRAP, oversize, byte, wrap-around, reserved
        for (int i = 0; i < 8; i++) begin
            issue_a(vecs[i]);
            drain_a(100);
        end
        chk("tbl_done", 32'(a_done), 32'd9);
        chk("tbl_err", 32'(a_err), 32'd3);

        // Queue fill with RREADY low: one popped + four queued
        a_rready = 1'b0;
        exp_ready = 7'b0011111;
        for (int i = 0; i < 7; i++) begin
            a_araddr = vecs[i].addr; a_arlen = vecs[i].len; a_arsize = vecs[i].size; a_arburst = vecs[i].burst;
            a_arvalid = 1'b1;
            chk("fill_arready", 32'(a_arready), 32'(exp_ready[i]));
            if (a_arready) push_exp_a(vecs[i]);
            tick();
        end
        a_arvalid = 1'b0;
        a_rready = 1'b1;
        drain_a(300);
        chk("fill_done", 32'(a_done), 32'd14);
        chk("fill_err", 32'(a_err), 32'd5);

        // Backpressure on the counter pattern: values 0..7 in order
        issue_b(8'd7);
        push_cnt_b(32'd0, 7);
        n = 0;
        while (qb.size() != 0 && n < 200) begin b_rready = ~b_rready; tick(); n++; end
        chk("bp_drain_left", 32'(qb.size()), 32'd0);

        // Bubble after every second accepted beat
        b_rready = 1'b1;
        issue_b(8'd5);
        push_cnt_b(32'd8, 5);
        n = 0;
        while (!b_rvalid && n < 20) begin tick(); n++; end
        stall_pat = 8'b11011011;
        for (int k = 0; k < 8; k++) begin
            chk("stall_rvalid", 32'(b_rvalid), 32'(stall_pat[7-k]));
            tick();
        end
        chk("stall_drain_left", 32'(qb.size()), 32'd0);
        chk("b_done", 32'(b_done), 32'd2);
        chk("b_err", 32'(b_err), 32'd0);

        // Reset while beat 2 of an 8-beat burst is presented
        v = '{32'h8000, 8'd7, 3'd2, 2'b01, 2'b00, 32'h8000, 32'd4};
        issue_a(v);
        n = 0;
        while (qa.size() > 6 && n < 50) begin tick(); n++; end
        chk("mid_rvalid_before", 32'(a_rvalid), 32'd1);
        rstn = 1'b0;
        tick();
        chk("mid_rvalid_after", 32'(a_rvalid), 32'd0);
        qa.delete();
        tick();
        chk("mid_arready_in_rst", 32'(a_arready), 32'd0);
        rstn = 1'b1;
        tick();
        chk("mid_arready_rel", 32'(a_arready), 32'd1);
        chk("mid_done", 32'(a_done), 32'd0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_rvalid) cnt++;
            tick();
        end
        chk("mid_no_beats", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
